// File: rtl/video_pkg.sv
// video_pkg: shared geometry types and a saturating counter helper for resolution detection
package video_pkg;
  localparam int DIM_W = 12;
  typedef logic [DIM_W-1:0] dim_t;
  localparam dim_t DIM_MAX = 12'd4095;
  function automatic dim_t sat_inc(input dim_t x);
    return (x == DIM_MAX) ? x : x + 1'b1;
  endfunction
endpackage

// File: rtl/video_res_detect_if.sv
// video_res_detect_if: pixel stream in, confirmed geometry out
interface video_res_detect_if;
  import video_pkg::*;
  logic CE_PIXEL;
  logic VGA_DE;
  logic VGA_HS;
  logic VGA_VS;
  dim_t hsize;
  dim_t vsize;
  logic valid;
  logic changed;
  modport slave(input CE_PIXEL, VGA_DE, VGA_HS, VGA_VS, output hsize, vsize, valid, changed);
  modport master(output CE_PIXEL, VGA_DE, VGA_HS, VGA_VS, input hsize, vsize, valid, changed);
endinterface

// File: rtl/video_frame_filter.sv
// video_frame_filter: debounces frame candidates, tracks VS timeout and publishes sizes
module video_frame_filter
  import video_pkg::*;
#(
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic vs_rise,
  input  dim_t cand_h,
  input  dim_t cand_v,
  output dim_t hsize,
  output dim_t vsize,
  output logic valid,
  output logic changed
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  dim_t prev_h, prev_v;
  logic [3:0] scnt, scnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic empty, same, publish, timeout;
  always_comb begin
    tcnt_n = vs_rise ? '0 : (tcnt == T_MAX) ? tcnt : tcnt + 1'b1;
    timeout = tcnt_n == T_MAX;
    empty = cand_h == '0 || cand_v == '0;
    same = cand_h == prev_h && cand_v == prev_v;
    scnt_n = empty ? 4'd0 : !same ? 4'd1 : (scnt == 4'd15) ? scnt : scnt + 1'b1;
    publish = strobe && !empty && scnt_n >= 4'(STABLE_FRAMES) &&
              (!valid || cand_h != hsize || cand_v != vsize);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      scnt <= '0;
      prev_h <= '0;
      prev_v <= '0;
      hsize <= '0;
      vsize <= '0;
      valid <= 1'b0;
      changed <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      changed <= publish;
      // a lost source forces the next confirmed frame to republish
      if (timeout) begin
        valid <= 1'b0;
        scnt <= '0;
      end else if (strobe) begin
        scnt <= scnt_n;
        if (!empty) begin
          prev_h <= cand_h;
          prev_v <= cand_v;
        end
      end
      if (publish) begin
        hsize <= cand_h;
        vsize <= cand_v;
        valid <= 1'b1;
      end
    end
endmodule

// File: rtl/video_res_detect.sv
// video_res_detect: measures active width/height of the pixel stream and publishes stable sizes
module video_res_detect
  import video_pkg::*;
#(
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input logic CLK_VIDEO,
  input logic RESET_N,
  video_res_detect_if.slave bus
);
  logic de_q, vs_q, seen;
  logic de_fall, vs_rise, line_ok;
  dim_t hcnt, hmax, lcnt, hmax_n, lcnt_n;
  logic unused_hs;
  assign unused_hs = bus.VGA_HS;
  // a line ending on the VS edge itself still belongs to the closing frame
  always_comb begin
    de_fall = bus.CE_PIXEL && de_q && !bus.VGA_DE;
    vs_rise = bus.CE_PIXEL && bus.VGA_VS && !vs_q;
    line_ok = de_fall && hcnt != '0;
    hmax_n = (line_ok && hcnt > hmax) ? hcnt : hmax;
    lcnt_n = line_ok ? sat_inc(lcnt) : lcnt;
  end
  always_ff @(posedge CLK_VIDEO or negedge RESET_N)
    if (!RESET_N) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      seen <= 1'b0;
      hcnt <= '0;
      hmax <= '0;
      lcnt <= '0;
    end else if (bus.CE_PIXEL) begin
      de_q <= bus.VGA_DE;
      vs_q <= bus.VGA_VS;
      seen <= seen || vs_rise;
      hcnt <= (vs_rise || de_fall) ? '0 : bus.VGA_DE ? sat_inc(hcnt) : hcnt;
      hmax <= vs_rise ? '0 : hmax_n;
      lcnt <= vs_rise ? '0 : lcnt_n;
    end
  // the first close after reset covers a partial frame and is never offered
  video_frame_filter #(
    .STABLE_FRAMES(STABLE_FRAMES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_filter (
    .clk(CLK_VIDEO),
    .rst_n(RESET_N),
    .strobe(vs_rise && seen),
    .vs_rise(vs_rise),
    .cand_h(hmax_n),
    .cand_v(lcnt_n),
    .hsize(bus.hsize),
    .vsize(bus.vsize),
    .valid(bus.valid),
    .changed(bus.changed)
  );
endmodule
